// File: rtl/fpm_pkg.sv
// Shared definitions for the floating-point multiplier datapath: operand
// widths and the skid-buffer state encoding (also reported as occupancy).
package fpm_pkg;

    localparam int FPM_MANT_W  = 25;  // mantissa + hidden bit + guard
    localparam int FPM_OPND_CH = 2;   // operand channels per transfer

    // State value equals the number of entries held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/operand_skid_ctrl.sv
// Control for the 2-entry operand skid buffer: FSM, push/pop decode,
// registered in_ready and register load selects.
// Optional feature: OPERAND_SKID_FLUSH_EN adds a synchronous flush input.
//
// Handshake: a transfer moves on a rising edge where valid & ready are both
// high; in_ready depends only on state (registered), and out_valid depends
// only on state, so neither output looks at the opposite side's input.
module operand_skid_ctrl
    import fpm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        out_ready,
`ifdef OPERAND_SKID_FLUSH_EN
    input  logic        flush,
`endif
    output logic        in_ready,
    output logic        out_valid,
    output logic        load_main,
    output logic        load_skid,
    output logic        main_from_skid,
    output skid_state_e state
);

    skid_state_e state_q;
    skid_state_e state_d;
    logic        push;
    logic        pop;
    logic        flush_req;

`ifdef OPERAND_SKID_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign state     = state_q;

    // Register selects; a flush drops the pushed transfer and leaves data alone.
    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!flush_req) begin
            case (state_q)
                EMPTY: load_main = push;
                ONE: begin
                    load_main = push & pop;
                    load_skid = push & ~pop;
                end
                TWO: begin
                    load_main      = pop;
                    main_from_skid = pop;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode; flush overrides any simultaneous push/pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush_req) state_d = EMPTY;
    end

    // State and registered in_ready, both taken from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != TWO);
        end
    end

endmodule

// File: rtl/operand_skid_regfile.sv
// Two-entry skid buffer carrying NCH operand channels of N bits between the
// unpack/align stage and the mantissa multiplier. out_data is driven from
// the main register; the skid register catches a transfer during a stall.
// Optional feature: OPERAND_SKID_FLUSH_EN adds the flush input.
module operand_skid_regfile
    import fpm_pkg::*;
#(
    parameter int N   = FPM_MANT_W,
    parameter int NCH = FPM_OPND_CH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH*N-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NCH*N-1:0] out_data,
`ifdef OPERAND_SKID_FLUSH_EN
    input  logic             flush,
`endif
    output logic [1:0]       occupancy
);

    logic        load_main;
    logic        load_skid;
    logic        main_from_skid;
    skid_state_e state;

    operand_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
`ifdef OPERAND_SKID_FLUSH_EN
        .flush          (flush),
`endif
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .load_main      (load_main),
        .load_skid      (load_skid),
        .main_from_skid (main_from_skid),
        .state          (state)
    );

    assign occupancy = state;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [N-1:0] main_q;
        logic [N-1:0] skid_q;

        // Per-channel main/skid registers; all channels load together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_skid) skid_q <= in_data[c*N +: N];
                if (load_main) main_q <= main_from_skid ? skid_q : in_data[c*N +: N];
            end
        end

        assign out_data[c*N +: N] = main_q;
    end

endmodule
